// File: rtl/dbus_pkg.sv
// Shared definitions for the dBus data memory: size encodings, FSM states, lane decode.
package dbus_pkg;

  localparam logic [1:0] DBUS_SIZE_B = 2'd0;
  localparam logic [1:0] DBUS_SIZE_H = 2'd1;
  localparam logic [1:0] DBUS_SIZE_W = 2'd2;

  typedef enum logic {
    StIdle,
    StBusy
  } dbus_state_e;

  // Byte-lane enables for a naturally sized access; the illegal size enables nothing.
  function automatic logic [3:0] dbus_byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      DBUS_SIZE_B: be = 4'b0001 << addr_lo;
      DBUS_SIZE_H: be = 4'b0011 << addr_lo;
      DBUS_SIZE_W: be = 4'b1111;
      default:     be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dbus_bytemem.sv
// Byte-lane RAM: one byte-enabled write port, one registered read port.
module dbus_bytemem
  import dbus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  // Plain unpacked array so simulation can load it through the hierarchy.
  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // Lane-masked write; contents are never reset.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we && i_be[b]) begin
        r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // Registered read; holds the last word read until the next read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= 32'h0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dbus_sram_ctrl.sv
// VexRiscv simple-dBus data memory with lane writes, fault detection and wait states.
module dbus_sram_ctrl
  import dbus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dBus_cmd_valid,
  output logic        dBus_cmd_ready,
  input  logic        dBus_cmd_payload_wr,
  input  logic [31:0] dBus_cmd_payload_address,
  input  logic [31:0] dBus_cmd_payload_data,
  input  logic [1:0]  dBus_cmd_payload_size,
  output logic        dBus_rsp_ready,
  output logic        dBus_rsp_error,
  output logic [31:0] dBus_rsp_data,
  output logic        err_flag
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);
  localparam logic [2:0]  WS   = 3'(WAIT_STATES);

  dbus_state_e r_state, w_state_nxt;
  logic [2:0]    r_cnt, w_cnt_nxt;
  logic          w_done;

  logic          w_accept;
  logic [31:0]   w_off;
  logic          w_in_range;
  logic          w_misalign;
  logic          w_fault;
  logic [3:0]    w_be;
  logic [AW-1:0] w_idx;

  logic [AW-1:0] r_idx;
  logic          r_pend_load;
  logic          r_pend_fault;

  logic          w_we;
  logic          w_re;
  logic [AW-1:0] w_raddr;
  logic          w_rsp_fire;
  logic          w_rsp_fault;
  logic [31:0]   w_rdata;

  logic          r_rsp_ready;
  logic          r_rsp_err;
  logic          r_err_flag;

  // Command decode and fault detection, purely combinational on the command bus.
  always_comb begin
    w_accept   = dBus_cmd_valid && dBus_cmd_ready;
    // Unsigned offset: addresses below the base wrap high and fail the range check.
    w_off      = dBus_cmd_payload_address - BASE_ADDR;
    w_in_range = w_off < SPAN;
    w_misalign = 1'b0;
    case (dBus_cmd_payload_size)
      DBUS_SIZE_B: w_misalign = 1'b0;
      DBUS_SIZE_H: w_misalign = dBus_cmd_payload_address[0];
      DBUS_SIZE_W: w_misalign = |dBus_cmd_payload_address[1:0];
      default:     w_misalign = 1'b1;
    endcase
    w_fault = !w_in_range || w_misalign;
    w_be    = dbus_byte_en(dBus_cmd_payload_size, dBus_cmd_payload_address[1:0]);
    w_idx   = w_off[AW+1:2];
    w_we    = w_accept && dBus_cmd_payload_wr && !w_fault;
  end

  // Wait-state FSM: next state, counter and ready.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_done         = 1'b0;
    dBus_cmd_ready = 1'b0;
    case (r_state)
      StIdle: begin
        dBus_cmd_ready = 1'b1;
        if (dBus_cmd_valid && (WS != 3'd0)) begin
          w_state_nxt = StBusy;
          w_cnt_nxt   = WS;
        end
      end
      StBusy: begin
        if (r_cnt == 3'd1) begin
          w_state_nxt = StIdle;
          w_cnt_nxt   = 3'd0;
          w_done      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
    endcase
  end

  // FSM state and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Response scheduling. With wait states the RAM read is deferred to the final busy
  // edge: nothing can write while busy, and the previous response stays stable until then.
  always_comb begin
    if (WS == 3'd0) begin
      w_re        = w_accept && !dBus_cmd_payload_wr && !w_fault;
      w_raddr     = w_idx;
      w_rsp_fire  = w_accept && !dBus_cmd_payload_wr;
      w_rsp_fault = w_fault;
    end else begin
      w_re        = w_done && r_pend_load && !r_pend_fault;
      w_raddr     = r_idx;
      w_rsp_fire  = w_done && r_pend_load;
      w_rsp_fault = r_pend_fault;
    end
  end

  // Capture the accepted command for the deferred response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx        <= '0;
      r_pend_load  <= 1'b0;
      r_pend_fault <= 1'b0;
    end else if (w_accept) begin
      r_idx        <= w_idx;
      r_pend_load  <= !dBus_cmd_payload_wr;
      r_pend_fault <= w_fault;
    end
  end

  // Response pulse, held error status and sticky fault flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_ready <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_err_flag  <= 1'b0;
    end else begin
      r_rsp_ready <= w_rsp_fire;
      if (w_rsp_fire) begin
        r_rsp_err <= w_rsp_fault;
      end
      if (w_accept && w_fault) begin
        r_err_flag <= 1'b1;
      end
    end
  end

  dbus_bytemem #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_mem (
    .i_clk  (clk),
    .i_rst_n(reset_n),
    .i_we   (w_we),
    .i_be   (w_be),
    .i_waddr(w_idx),
    .i_wdata(dBus_cmd_payload_data),
    .i_re   (w_re),
    .i_raddr(w_raddr),
    .o_rdata(w_rdata)
  );

  // A faulted load reports zero data; the RAM read register is left untouched.
  assign dBus_rsp_data  = r_rsp_err ? 32'h0 : w_rdata;
  assign dBus_rsp_ready = r_rsp_ready;
  assign dBus_rsp_error = r_rsp_err;
  assign err_flag       = r_err_flag;

endmodule

// File: doc/dbus_sram_ctrl.md
# dbus_sram_ctrl

Parametrised data-bus memory for the VexRiscv simple dBus, replacing the fixed 4 MiB word RAM in the tiny SoC. It adds four things: correct byte-lane writes from address offset and size, address-window and alignment error detection, configurable wait states, and a sticky error flag. It sits between the CPU dBus port and the SoC's data memory. The instruction-side memory is unchanged.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; must be aligned to `DEPTH_WORDS*4`.
- `DEPTH_WORDS`, 1024: memory depth in 32-bit words; power of two, 16..1048576.
- `WAIT_STATES`, 0: extra busy cycles per command, 0..7.

Ports:
- `clk`  in  1  clock; all state is updated on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `dBus_cmd_valid`  in  1  command request.
- `dBus_cmd_ready`  out  1  command accepted when high together with valid.
- `dBus_cmd_payload_wr`  in  1  1 = store, 0 = load.
- `dBus_cmd_payload_address`  in  32  byte address.
- `dBus_cmd_payload_data`  in  32  store data, already lane-replicated by the CPU.
- `dBus_cmd_payload_size`  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- `dBus_rsp_ready`  out  1  one-cycle pulse: load response valid.
- `dBus_rsp_error`  out  1  qualifies `dBus_rsp_ready`; the load faulted.
- `dBus_rsp_data`  out  32  full aligned word; the CPU selects lanes.
- `err_flag`  out  1  sticky; set by any faulting command, cleared only by reset.

## Operation
- Accept = `dBus_cmd_valid && dBus_cmd_ready`.
- Word index = `(address - BASE_ADDR) >> 2`.
- Fault conditions:
  - address outside `[BASE_ADDR, BASE_ADDR + DEPTH_WORDS*4)`;
  - size 1 with `address[0]` = 1;
  - size 2 with `address[1:0]` != 0;
  - size 3.
- Byte enables:
  - size 0: `4'b0001 << addr[1:0]`;
  - size 1: `4'b0011 << addr[1:0]`;
  - size 2: `4'b1111`.
- Store:
  - commits enabled lanes at the accept edge;
  - a faulting store writes nothing, sets `err_flag` and produces no response (the simple dBus has no store response).
- Load:
  - reads the whole word at accept;
  - a faulting load returns `dBus_rsp_error` = 1 with data 0 and sets `err_flag`.
- FSM states:
  - IDLE: `dBus_cmd_ready` = 1.
  - BUSY: `dBus_cmd_ready` = 0; a down-counter loaded with `WAIT_STATES` counts to zero.
- FSM transitions:
  - With `WAIT_STATES` = 0 there is no BUSY state and the block stays in IDLE.
  - IDLE -> BUSY on accept when `WAIT_STATES` > 0.
  - BUSY -> IDLE when the counter reaches 1 on a clock edge.
- Memory contents are not reset and are uninitialised in simulation.

## Timing
- Load accepted in cycle t: `dBus_rsp_ready` is high in cycle t+1+`WAIT_STATES`, for exactly one cycle. Data and error are valid in that same cycle.
- `dBus_rsp_data` and `dBus_rsp_error` hold their values until the next load response.
- `dBus_cmd_ready` is low in cycles t+1 .. t+`WAIT_STATES` and high again in cycle t+1+`WAIT_STATES`.
- A new accept may coincide with the previous response.
- With `WAIT_STATES` = 0 the block is fully pipelined: one accept per cycle and one response per load, one cycle later.
- Stores have the same busy timing as loads. Store data is visible to a load accepted in the next cycle the block is ready.
- At most one command is outstanding.
- Reset values: `dBus_cmd_ready` = 1, `dBus_rsp_ready` = 0, `dBus_rsp_error` = 0, `dBus_rsp_data` = 0, `err_flag` = 0; FSM in IDLE, counter = 0.
- Reset asserted mid-operation: the pending response is dropped, any in-flight counter is cleared, and an already committed store stays in memory.
- Size and range checks are combinational on the command bus in the accept cycle.

## Structure
- Shared package `dbus_pkg`:
  - size encodings `DBUS_SIZE_B`, `DBUS_SIZE_H`, `DBUS_SIZE_W`;
  - FSM state typedef (IDLE, BUSY);
  - function `dbus_byte_en(size, addr_lo)` returning 4 bits.
- Sub-module `dbus_bytemem`:
  - 4 byte-lane RAM, `DEPTH_WORDS` x 32;
  - one registered read port, one byte-enabled write port;
  - memory array marked public for simulation backdoor loading.
- Top level holds the decode, fault logic, FSM, counter, response registers and sticky flag.

## Test plan
- Reset: assert `reset_n` = 0 mid-load with `WAIT_STATES` = 3 -> no `dBus_rsp_ready` pulse; after release `dBus_cmd_ready` = 1 and `err_flag` = 0.
- Byte store: memory word 0 = 0, store size 0 at `BASE_ADDR`+1 with data 0xABABABAB -> load of `BASE_ADDR` returns 0x0000AB00, error 0.
- Half store: size 1 at +2 with 0x12341234 over word 0xFFFFFFFF -> load returns 0x1234FFFF.
- Misaligned: size 2 store at +2 -> memory unchanged, `err_flag` = 1, no response; size 1 load at +1 -> `dBus_rsp_error` = 1, data 0.
- Out of range: `DEPTH_WORDS` = 1024, load at `BASE_ADDR`+0x1000 -> `dBus_rsp_error` = 1; load at `BASE_ADDR`+0xFFC -> error 0.
- Timing:
  - `WAIT_STATES` = 2, load accepted at cycle 10 -> `dBus_cmd_ready` low in cycles 11-12, response in cycle 13.
  - `WAIT_STATES` = 0, four back-to-back loads -> responses in four consecutive cycles, in order.
